// File: rtl/fp_pkg.sv
// Shared FP32 field layout, special exponent codes, unpacked-float type and
// saturation constants for the float-to-fixed conversion path.
package fp_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MAN_W     = 23;
    localparam int unsigned SIG_W     = MAN_W + 1;
    localparam int unsigned SIGN_POS  = 31;
    localparam int unsigned EXP_LSB   = 23;
    localparam int unsigned MAN_LSB   = 0;

    localparam int              EXP_BIAS    = 127;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    // Widest fixed-point word the converter supports.
    localparam int unsigned SAT_MAX_W = 48;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_unpacked_t;

    // Split an FP32 word and classify it; exp == 0 carries no hidden bit.
    function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] w);
        fp_unpacked_t     u;
        logic [MAN_W-1:0] man;
        u.sign    = w[SIGN_POS];
        u.exp     = w[EXP_LSB +: EXP_W];
        man       = w[MAN_LSB +: MAN_W];
        u.sig     = {(u.exp != '0), man};
        u.is_zero = (u.exp == '0);
        u.is_inf  = (u.exp == EXP_SPECIAL) && (man == '0);
        u.is_nan  = (u.exp == EXP_SPECIAL) && (man != '0);
        return u;
    endfunction

    // Largest positive two's-complement value of an out_w-bit word.
    function automatic logic [SAT_MAX_W-1:0] sat_pos(input int unsigned out_w);
        return (SAT_MAX_W'(1) << (out_w - 1)) - SAT_MAX_W'(1);
    endfunction

    // Magnitude of the most negative out_w-bit value (also its bit pattern).
    function automatic logic [SAT_MAX_W-1:0] sat_neg(input int unsigned out_w);
        return SAT_MAX_W'(1) << (out_w - 1);
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational bidirectional barrel shifter: aligns a 24-bit significand
// to the fixed-point grid. Left shifts flag any bit pushed beyond the
// (OUT_W+1)-bit magnitude; right shifts report guard and sticky bits.
module fp_align_shifter
    import fp_pkg::*;
#(
    parameter int unsigned OUT_W = 32
) (
    input  logic [SIG_W-1:0] i_sig,
    input  logic [9:0]       i_sh,     // two's complement, bit 9 is sign
    output logic [OUT_W:0]   o_mag,
    output logic             o_guard,
    output logic             o_sticky,
    output logic             o_ovf
);

    localparam int unsigned MAG_W = OUT_W + 1;
    localparam int unsigned LW    = MAG_W + SIG_W;
    localparam int unsigned RW    = 2 * SIG_W + 1;
    // Beyond this right shift every significand bit lands in sticky.
    localparam logic [9:0]  RSH_CLAMP = 10'(SIG_W + 1);

    logic [9:0]    w_lsh;
    logic [9:0]    w_rsh;
    logic [LW-1:0] w_left;
    logic [RW-1:0] w_right;
    logic [LW-1:0] w_rmag;

    // Select shift direction, then extract magnitude and lost-bit flags.
    always_comb begin
        o_mag    = '0;
        o_guard  = 1'b0;
        o_sticky = 1'b0;
        o_ovf    = 1'b0;
        w_lsh    = i_sh;
        w_rsh    = 10'd0 - i_sh;
        w_left   = '0;
        w_right  = '0;
        w_rmag   = '0;
        if (!i_sh[9]) begin
            if (w_lsh >= 10'(LW)) begin
                o_ovf = |i_sig;
            end else begin
                w_left = {{MAG_W{1'b0}}, i_sig} << w_lsh;
                o_mag  = w_left[MAG_W-1:0];
                o_ovf  = |w_left[LW-1:MAG_W];
            end
        end else begin
            if (w_rsh > RSH_CLAMP) begin
                w_rsh = RSH_CLAMP;
            end
            w_right  = {i_sig, {(SIG_W + 1){1'b0}}} >> w_rsh;
            w_rmag   = {{MAG_W{1'b0}}, w_right[RW-1:SIG_W+1]};
            o_mag    = w_rmag[MAG_W-1:0];
            // Only a narrow OUT_W can fail to hold a right-shifted significand.
            o_ovf    = |w_rmag[LW-1:MAG_W];
            o_guard  = w_right[SIG_W];
            o_sticky = |w_right[SIG_W-1:0];
        end
    end

endmodule

// File: rtl/fp_to_fixed_denorm.sv
// Three-stage FP32 to signed fixed-point converter with valid/ready on both
// sides. S1 unpacks, S2 aligns (and optionally rounds), S3 saturates,
// negates and drives the outputs.
// Optional: define FP2FIX_ROUND_EN for round-to-nearest-even on right
// shifts; otherwise magnitudes truncate toward zero.
module fp_to_fixed_denorm
    import fp_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 15,
    parameter int unsigned OUT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_inexact
);

    localparam int unsigned MAG_W  = OUT_W + 1;
    localparam int unsigned RND_W  = OUT_W + 2;
    localparam int          SH_OFS = int'(FRAC_BITS) - EXP_BIAS - int'(MAN_W);
    localparam logic [9:0]  SH_OFS_V = 10'(SH_OFS);

    localparam logic [SAT_MAX_W-1:0] SAT_POS_W = sat_pos(OUT_W);
    localparam logic [SAT_MAX_W-1:0] SAT_NEG_W = sat_neg(OUT_W);
    localparam logic [OUT_W-1:0]     SAT_POS   = SAT_POS_W[OUT_W-1:0];
    localparam logic [OUT_W-1:0]     SAT_NEG   = SAT_NEG_W[OUT_W-1:0];
    localparam logic [RND_W-1:0]     LIM_POS   = RND_W'(SAT_POS_W);
    localparam logic [RND_W-1:0]     LIM_NEG   = RND_W'(SAT_NEG_W);

    // Stage handshake
    logic w_ld1, w_ld2, w_ld3;

    // S1 state
    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [SIG_W-1:0] r_s1_sig;
    logic             r_s1_zero, r_s1_inf, r_s1_nan;
    logic [9:0]       r_s1_sh;

    // S2 state
    logic             r_s2_valid;
    logic             r_s2_sign;
    logic             r_s2_zero, r_s2_inf, r_s2_nan;
    logic             r_s2_ovf;
    logic             r_s2_inexact;
    logic [RND_W-1:0] r_s2_mag;

    // S3 / output state
    logic             r_s3_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_ovf;
    logic             r_out_inexact;

    // Combinational stage logic
    fp_unpacked_t     w_fp;
    logic [9:0]       w_sh;
    logic [MAG_W-1:0] w_sh_mag;
    logic             w_guard, w_sticky, w_sh_ovf;
    logic [RND_W-1:0] w_mag_rnd;
    logic             w_big;
    logic [OUT_W-1:0] w_mag_lo;
    logic [OUT_W-1:0] w_out_data;
    logic             w_out_ovf;
    logic             w_out_inexact;

    // A stage advances when empty or when its successor advances; no
    // dependence on in_valid so in_ready is free of input loops.
    always_comb begin
        w_ld3    = out_ready | ~r_s3_valid;
        w_ld2    = ~r_s2_valid | w_ld3;
        w_ld1    = ~r_s1_valid | w_ld2;
        in_ready = w_ld1;
    end

    // S1 decode: unpack fields and form the signed alignment shift.
    always_comb begin
        w_fp = fp_unpack(in_data);
        w_sh = {2'b00, w_fp.exp} + SH_OFS_V;
    end

    // S1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sig   <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_sh    <= '0;
        end else begin
            if (w_ld1) begin
                r_s1_valid <= in_valid;
            end
            if (w_ld1 && in_valid) begin
                r_s1_sign <= w_fp.sign;
                r_s1_sig  <= w_fp.sig;
                r_s1_zero <= w_fp.is_zero;
                r_s1_inf  <= w_fp.is_inf;
                r_s1_nan  <= w_fp.is_nan;
                r_s1_sh   <= w_sh;
            end
        end
    end

    fp_align_shifter #(
        .OUT_W (OUT_W)
    ) u_shifter (
        .i_sig    (r_s1_sig),
        .i_sh     (r_s1_sh),
        .o_mag    (w_sh_mag),
        .o_guard  (w_guard),
        .o_sticky (w_sticky),
        .o_ovf    (w_sh_ovf)
    );

    // S2 rounding: one extra bit keeps a round-up carry for the S3 check.
`ifdef FP2FIX_ROUND_EN
    logic w_round_up;
    always_comb begin
        w_round_up = w_guard & (w_sticky | w_sh_mag[0]);
        w_mag_rnd  = {1'b0, w_sh_mag} + {{(RND_W - 1){1'b0}}, w_round_up};
    end
`else
    always_comb begin
        w_mag_rnd = {1'b0, w_sh_mag};
    end
`endif

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_zero    <= 1'b0;
            r_s2_inf     <= 1'b0;
            r_s2_nan     <= 1'b0;
            r_s2_ovf     <= 1'b0;
            r_s2_inexact <= 1'b0;
            r_s2_mag     <= '0;
        end else begin
            if (w_ld2) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_ld2 && r_s1_valid) begin
                r_s2_sign    <= r_s1_sign;
                r_s2_zero    <= r_s1_zero;
                r_s2_inf     <= r_s1_inf;
                r_s2_nan     <= r_s1_nan;
                r_s2_ovf     <= w_sh_ovf;
                r_s2_inexact <= w_guard | w_sticky;
                r_s2_mag     <= w_mag_rnd;
            end
        end
    end

    // S3 saturate and negate; specials override the numeric path.
    always_comb begin
        w_big         = r_s2_ovf || (r_s2_mag > (r_s2_sign ? LIM_NEG : LIM_POS));
        w_mag_lo      = r_s2_mag[OUT_W-1:0];
        w_out_data    = r_s2_sign ? (~w_mag_lo + 1'b1) : w_mag_lo;
        w_out_ovf     = 1'b0;
        w_out_inexact = r_s2_inexact;
        if (r_s2_nan) begin
            w_out_data    = SAT_POS;
            w_out_ovf     = 1'b1;
            w_out_inexact = 1'b0;
        end else if (r_s2_inf) begin
            w_out_data    = r_s2_sign ? SAT_NEG : SAT_POS;
            w_out_ovf     = 1'b1;
            w_out_inexact = 1'b0;
        end else if (r_s2_zero) begin
            w_out_data    = '0;
            w_out_inexact = 1'b0;
        end else if (w_big) begin
            w_out_data = r_s2_sign ? SAT_NEG : SAT_POS;
            w_out_ovf  = 1'b1;
        end
    end

    // S3 output register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid    <= 1'b0;
            r_out_data    <= '0;
            r_out_ovf     <= 1'b0;
            r_out_inexact <= 1'b0;
        end else begin
            if (w_ld3) begin
                r_s3_valid <= r_s2_valid;
            end
            if (w_ld3 && r_s2_valid) begin
                r_out_data    <= w_out_data;
                r_out_ovf     <= w_out_ovf;
                r_out_inexact <= w_out_inexact;
            end
        end
    end

    assign out_valid   = r_s3_valid;
    assign out_data    = r_out_data;
    assign out_ovf     = r_out_ovf;
    assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fp_to_fixed_denorm.sv
// Self-checking bench for fp_to_fixed_denorm: directed vectors, stall and
// reset scenarios, then randomized traffic against an arithmetic model.
module tb_fp_to_fixed_denorm;

    localparam int unsigned FRAC = 15;
    localparam int unsigned OW   = 32;
    localparam logic [31:0] POS_SAT = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_SAT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        inex;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_ovf;
    logic          out_inexact;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   out_cyc  = 0;
    logic last_acc = 1'b0;
    logic saw_block = 1'b0;
    int   held_at_block = -1;

    logic        hold_pending = 1'b0;
    logic [31:0] hold_data;
    logic        hold_ovf, hold_inex;

    exp_t sb[$];

    fp_to_fixed_denorm #(
        .FRAC_BITS (FRAC),
        .OUT_W     (OW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Value * 2^FRAC = sig * 2^k; integer quotient/remainder gives the result.
    function automatic exp_t ref_model(input logic [31:0] w);
        exp_t         r;
        logic [127:0] sig, q, rem, half, lim;
        logic         big;
        int           ex, k, sh;
        r   = '0;
        big = 1'b0;
        q   = '0;
        rem = '0;
        half = '0;
        ex  = int'(w[30:23]);
        sig = {104'd0, 1'b1, w[22:0]};
        if (ex == 0) return r;
        if (ex == 255) begin
            r.ovf  = 1'b1;
            r.data = (w[22:0] == 23'd0 && w[31]) ? NEG_SAT : POS_SAT;
            return r;
        end
        k = ex - 150 + int'(FRAC);
        if (k >= 0) begin
            if (k > 90) big = 1'b1;
            else q = sig << k;
        end else begin
            sh = -k;
            if (sh > 40) begin
                r.inex = 1'b1;
            end else begin
                q      = sig >> sh;
                rem    = sig - (q << sh);
                r.inex = (rem != 0);
`ifdef FP2FIX_ROUND_EN
                half = 128'd1 << (sh - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
            end
        end
        lim = w[31] ? (128'd1 << (OW - 1)) : ((128'd1 << (OW - 1)) - 1);
        if (big || q > lim) begin
            r.ovf  = 1'b1;
            r.data = w[31] ? NEG_SAT : POS_SAT;
        end else begin
            r.data = w[31] ? 32'(-q) : q[31:0];
        end
        return r;
    endfunction

    // One cycle: drive at negedge, observe transfers that the next edge makes.
    task automatic step(input logic v, input logic [31:0] d, input exp_t e, input logic r);
        exp_t x;
        @(negedge clk);
        if (hold_pending) begin
            check_eq("stall_valid", 64'(out_valid), 64'd1);
            check_eq("stall_data", 64'(out_data), 64'(hold_data));
            check_eq("stall_ovf", 64'(out_ovf), 64'(hold_ovf));
            check_eq("stall_inexact", 64'(out_inexact), 64'(hold_inex));
            hold_pending = 1'b0;
        end
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        last_acc = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_word", 64'd1, 64'd0);
            end else begin
                x = sb.pop_front();
                check_eq("data", 64'(out_data), 64'(x.data));
                check_eq("ovf", 64'(out_ovf), 64'(x.ovf));
                check_eq("inexact", 64'(out_inexact), 64'(x.inex));
                out_cyc = cyc;
            end
        end else if (out_valid) begin
            hold_pending = 1'b1;
            hold_data    = out_data;
            hold_ovf     = out_ovf;
            hold_inex    = out_inexact;
        end
        if (in_valid && !in_ready && !saw_block) begin
            saw_block     = 1'b1;
            held_at_block = sb.size();
        end
        if (in_valid && in_ready) begin
            sb.push_back(e);
            acc_cyc  = cyc;
            last_acc = 1'b1;
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) step(1'b0, '0, '0, 1'b1);
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic send_directed(input logic [31:0] d, input exp_t e);
        step(1'b1, d, e, 1'b1);
        check_eq("accepted", 64'(last_acc), 64'd1);
        drain();
        check_eq("latency", 64'(out_cyc - acc_cyc), 64'd3);
    endtask

    logic [31:0] dir_in  [11];
    exp_t        dir_exp [11];
    logic [31:0] words   [10];

    initial begin
        logic [31:0] pend;
        logic        have_pend;
        int          idx;
        int          rel;

        dir_in[0]  = 32'h3F80_0000; dir_exp[0]  = '{32'h0000_8000, 1'b0, 1'b0};
        dir_in[1]  = 32'hC020_0000; dir_exp[1]  = '{32'hFFFE_C000, 1'b0, 1'b0};
        dir_in[2]  = 32'hC780_0000; dir_exp[2]  = '{32'h8000_0000, 1'b0, 1'b0};
        dir_in[3]  = 32'h4780_0000; dir_exp[3]  = '{32'h7FFF_FFFF, 1'b1, 1'b0};
`ifdef FP2FIX_ROUND_EN
        dir_in[4]  = 32'h37C0_0000; dir_exp[4]  = '{32'h0000_0001, 1'b0, 1'b1};
`else
        dir_in[4]  = 32'h37C0_0000; dir_exp[4]  = '{32'h0000_0000, 1'b0, 1'b1};
`endif
        dir_in[5]  = 32'h3780_0000; dir_exp[5]  = '{32'h0000_0000, 1'b0, 1'b1};
        dir_in[6]  = 32'h7F80_0000; dir_exp[6]  = '{32'h7FFF_FFFF, 1'b1, 1'b0};
        dir_in[7]  = 32'hFF80_0000; dir_exp[7]  = '{32'h8000_0000, 1'b1, 1'b0};
        dir_in[8]  = 32'h7FC0_0000; dir_exp[8]  = '{32'h7FFF_FFFF, 1'b1, 1'b0};
        dir_in[9]  = 32'h0040_0000; dir_exp[9]  = '{32'h0000_0000, 1'b0, 1'b0};
        dir_in[10] = 32'hC780_0001; dir_exp[10] = '{32'h8000_0000, 1'b1, 1'b0};

        // Reset state
        #3;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_ovf", 64'(out_ovf), 64'd0);
        check_eq("rst_out_inexact", 64'(out_inexact), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 11; i++) send_directed(dir_in[i], dir_exp[i]);

        // Back-to-back stream with downstream stalled for relative cycles 4..8
        for (int i = 0; i < 10; i++) words[i] = 32'h3F80_0000 + (32'(i) << 19);
        idx = 0;
        rel = 0;
        saw_block = 1'b0;
        while (idx < 10 && rel < 100) begin
            step(1'b1, words[idx], ref_model(words[idx]), !(rel >= 4 && rel <= 8));
            if (last_acc) idx++;
            rel++;
        end
        check_eq("stream_all_accepted", 64'(idx), 64'd10);
        check_eq("in_ready_dropped", 64'(saw_block), 64'd1);
        check_eq("held_when_blocked", 64'(held_at_block), 64'd3);
        drain();

        // Reset with two words in flight, first one presented and stalled
        step(1'b1, 32'h4000_0000, ref_model(32'h4000_0000), 1'b0);
        step(1'b1, 32'h4040_0000, ref_model(32'h4040_0000), 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        check_eq("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(out_valid), 64'd0);
        check_eq("async_rst_data", 64'(out_data), 64'd0);
        sb.delete();
        hold_pending = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        send_directed(32'hC020_0000, '{32'hFFFE_C000, 1'b0, 1'b0});

        // Randomized traffic with random backpressure
        have_pend = 1'b0;
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            logic v;
            if (!have_pend) begin
                int sel;
                sel = $urandom_range(0, 19);
                pend = $urandom();
                if (sel == 0) pend[30:23] = 8'h00;
                else if (sel == 1) pend[30:23] = 8'hFF;
                else if (sel == 2) begin
                    pend[30:23] = 8'hFF;
                    pend[22:0]  = '0;
                end else pend[30:23] = 8'($urandom_range(95, 150));
                have_pend = 1'b1;
            end
            v = ($urandom_range(0, 3) != 0);
            step(v, pend, ref_model(pend), ($urandom_range(0, 9) < 7));
            if (last_acc) have_pend = 1'b0;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_to_fixed_denorm.md
# fp_to_fixed_denorm

Pipelined IEEE-754 single-precision to signed fixed-point converter with a valid/ready stream on both sides. It is the inverse of the normalization path in the butterfly datapath. The leading-one encoder plus normalizer turn a fixed significand into exponent and mantissa; this block expands exponent and mantissa back into a two's-complement fixed-point word for the integer twiddle/accumulator stages. It sits between the floating-point butterfly outputs and the fixed-point output buffer.

## Interface
- FRAC_BITS, 15: number of fractional bits in the output word.
- OUT_W, 32: output word width; legal range 16..48, and must satisfy OUT_W > FRAC_BITS + 1.
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  32  IEEE-754 single {sign, exp[7:0], man[22:0]}.
- out_valid  out  1  out_data and flags are valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  OUT_W  signed fixed-point result, FRAC_BITS fractional bits.
- out_ovf  out  1  result saturated (overflow, Inf, or NaN).
- out_inexact  out  1  nonzero bits were discarded by the right shift.

## Operation
- A transfer occurs on any edge where valid && ready. Input and output behave independently.
- Unpack:
  - hidden = (exp != 0).
  - sig[23:0] = {hidden, man}.
  - exp == 0 (zero or denormal) is flushed to result 0 with no flags.
- Shift amount: sh = exp − 127 + FRAC_BITS − 23, a signed 10-bit value.
- sh ≥ 0: magnitude = sig << sh.
  - Overflow if the magnitude exceeds 2^(OUT_W−1)−1 for positive inputs, or 2^(OUT_W−1) for negative inputs.
  - Compute with an (OUT_W+1)-bit magnitude. Any bit shifted beyond that width also counts as overflow.
- sh < 0: magnitude = sig >> −sh.
  - −sh ≥ 25 gives magnitude 0.
  - out_inexact = OR of the discarded bits.
- Sign is applied last: out_data = sign ? −mag : mag.
- Saturation:
  - Positive → 0x7FF…F; negative → 0x800…0; out_ovf = 1.
  - Inf (exp = 255, man = 0) saturates by sign.
  - NaN (exp = 255, man ≠ 0) → positive saturation, out_ovf = 1.
- Pipeline has three registered stages, each with its own valid bit:
  - S1: unpack, sh, special-case decode.
  - S2: barrel shift, sticky/inexact, rounding.
  - S3: saturate, negate, output register. S3 drives the out_* ports.
- Flow control: stage k loads when stage k is empty or stage k+1 loads. S3 "loads" when out_ready = 1 or out_valid = 0. Bubbles collapse.
- in_ready = !S1.valid || S1 loads. This is combinational from out_ready through the stage valids; there is no combinational path from in_valid.

## Timing
- Latency: 3 cycles from an accepting edge to out_valid, with an unstalled pipeline.
- Throughput: 1 word/cycle.
- Reset (asynchronous, rst_n = 0):
  - All stage valids clear; out_valid = 0, out_data = 0, out_ovf = 0, out_inexact = 0.
  - in_ready = 1 once rst_n deasserts.
- Reset asserted mid-operation: in-flight words are dropped immediately. No partial word is presented afterwards.
- Stall: while out_valid = 1 && out_ready = 0, all out_* ports hold stable. Up to 3 words are held internally. No word is lost or reordered.
- Simultaneous out_ready and in_valid with a full pipeline: input is accepted in the same cycle (pass-through advance).

## Configuration
- FP2FIX_ROUND_EN defined:
  - The S2 right shift rounds to nearest, ties to even, on the magnitude, using guard and sticky bits.
  - A round-up carry is re-checked for overflow in S3.
  - out_inexact is still reported.
- FP2FIX_ROUND_EN undefined:
  - Magnitude truncation, i.e. round toward zero. No rounding adder.
  - Latency is unchanged.

## Structure
- Package fp_pkg holds:
  - FP32 field widths and positions.
  - EXP_BIAS = 127 and EXP_SPECIAL = 8'hFF.
  - An unpacked-float struct typedef {sign, exp, sig[23:0], is_zero, is_inf, is_nan}.
  - Saturation constant functions parameterized by OUT_W.
- One sub-module, fp_align_shifter:
  - Combinational bidirectional barrel shifter.
  - Outputs: magnitude, guard, sticky, overflow.
  - Instantiated in S2.

## Test plan
Defaults FRAC_BITS = 15, OUT_W = 32.
- 0x3F800000 (1.0) → out_data 0x00008000; ovf 0, inexact 0; out_valid 3 cycles after the accepting edge.
- 0xC0200000 (−2.5) → 0xFFFEC000. 0xC7800000 (−65536.0) → 0x80000000, ovf 0. 0x47800000 (65536.0) → 0x7FFFFFFF, ovf 1.
- 0x37C00000 (0.75 LSB):
  - Without FP2FIX_ROUND_EN → 0x00000000, inexact 1.
  - With FP2FIX_ROUND_EN → 0x00000001.
  - 0x37800000 (0.5 LSB, tie) → 0 in both modes, inexact 1.
- 0x7F800000 → 0x7FFFFFFF ovf 1. 0xFF800000 → 0x80000000 ovf 1. 0x7FC00000 → 0x7FFFFFFF ovf 1. 0x00400000 (denormal) → 0, no flags.
- Stream 10 back-to-back words while out_ready is held low for cycles 4..8:
  - in_ready drops once 3 words are held.
  - All 10 words emerge in order with out_* stable while stalled.
- Assert rst_n = 0 for 1 cycle with 2 words in flight:
  - out_valid falls asynchronously; neither word appears afterwards.
  - The next accepted word emerges 3 cycles later.
